dmem_store_buffer: RTL
======================

// Module: dmem_store_buffer
// PURPOSE
//  Posted-write store buffer between the pipelined core's data-memory port (MEM stage) and data memory.
//  - Stores from the core's MEM stage are queued in a FIFO and drained to memory over a valid/ready write channel.
//  - Loads read memory combinationally; pending buffered stores to the same word are forwarded into the load result.
//  - Raises a stall to the core only when a store arrives while the buffer is full and cannot drain.
// PARAMETERS
//  DEPTH  4   store entries; power of two, >= 2
//  AW     32  address width
//  DW     32  data width
// PORTS
//  clk               in   1   clock
//  reset             in   1   asynchronous, active-low reset
//  cpu_memwrite      in   1   store request from MEM stage
//  cpu_memaddr       in   AW  byte address (store or load)
//  cpu_memwritedata  in   DW  store data
//  cpu_memreaddata   out  DW  load data to MEM/WB, forwarded where applicable
//  cpu_stall         out  1   store not accepted this cycle; core must hold MEM stage
//  mem_wr_valid      out  1   head entry presented to memory
//  mem_wr_ready      in   1   memory accepts head entry this cycle
//  mem_wr_addr       out  AW  head entry address
//  mem_wr_data       out  DW  head entry data
//  mem_rd_addr       out  AW  load address to memory (= cpu_memaddr)
//  mem_rd_data       in   DW  combinational read data from memory
//  sb_count          out  $clog2(DEPTH)+1  occupied entries
//  sb_empty          out  1   sb_count == 0
// BEHAVIOUR
//  - Reset (reset low, async): head/tail pointers 0, sb_count 0, all entry valid bits 0.
//    mem_wr_valid=0, sb_empty=1, cpu_stall=0. mem_wr_addr/data are don't-care but driven 0.
//  - Reset mid-operation discards all pending stores; nothing further is issued.
//  - FIFO: circular, pointers wrap modulo DEPTH; sb_count tracks occupancy, 0..DEPTH.
//  - Drain (head retire):
//    - mem_wr_valid = !sb_empty; mem_wr_addr/mem_wr_data = head entry.
//    - Head is retired on the clk edge where mem_wr_valid & mem_wr_ready.
//    - Addr/data remain stable while valid & !ready.
//  - Enqueue: on the clk edge where cpu_memwrite & (!full | mem_wr_ready).
//    - Full with a simultaneous drain: enqueue and retire happen in the same cycle, so sb_count is unchanged.
//    - Empty with a store: entry is written this edge; mem_wr_valid rises the next cycle (1-cycle latency).
//  - cpu_stall = cpu_memwrite & full & !mem_wr_ready (combinational).
//    Core holds addr/data stable until cpu_stall drops.
//  - Load forwarding (combinational, every cycle cpu_memwrite=0):
//    - Compare cpu_memaddr[AW-1:2] against every valid entry.
//    - Match: cpu_memreaddata = data of the NEWEST matching entry, measured from tail backwards.
//    - No match: cpu_memreaddata = mem_rd_data.
//    - The head entry being retired this cycle still counts as a match.
//    - With cpu_memwrite=1, cpu_memreaddata = mem_rd_data (don't-care to core).
//  - Word-granular only: addr[1:0] ignored for matching; full-word stores only.
//  - Store order to memory is strictly program order (FIFO).
// CONFIGURATION
//  - STORE_BUF_COALESCE_EN defined:
//    - Condition: a store whose word address matches the newest entry (tail-1), where that entry is not the
//      head currently presented with mem_wr_valid=1.
//    - Action: overwrite that entry's data. No new entry is allocated and sb_count is unchanged.
//    - Coalescing takes precedence over the full check, so cpu_stall=0 in that case.
//  - STORE_BUF_COALESCE_EN undefined: every accepted store allocates a new entry.
// TESTING
//  1. Reset: reset=0 mid-drain with 3 entries -> next cycle sb_count=0, mem_wr_valid=0, sb_empty=1.
//     No mem write after release.
//  2. mem_wr_ready=1; stores 0x100<-0xAAAA0001, 0x104<-0xBBBB0002 -> memory sees both, in order,
//     1 cycle after each enqueue.
//  3. mem_wr_ready=0; 4 stores fill buffer; 5th store -> cpu_stall=1, sb_count=4.
//     Raise ready -> stall drops same cycle, 5th accepted, sb_count stays 4.
//  4. Forwarding: ready=0; store 0x200<-0x11, then 0x200<-0x22; load 0x200 -> 0x22.
//     Load 0x202 -> 0x22. Load 0x300 -> mem_rd_data.
//  5. Wrap: ready toggled 1/0 over 10 stores (addr 0x0..0x24) -> all 10 written in order; pointers wrap cleanly.
//  6. COALESCE_EN: ready=0; stores 0x40<-1, 0x80<-2, 0x80<-3 -> sb_count=2, drained data at 0x80 = 3.
//     Without the macro -> sb_count=3.

Source files
------------

// File: rtl/dmem_store_buffer_if.sv
// Core/memory-side bundle for the posted-write store buffer: MEM-stage port,
// memory write channel, combinational memory read path and occupancy status.
interface dmem_store_buffer_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          cpu_memwrite;
    logic [AW-1:0] cpu_memaddr;
    logic [DW-1:0] cpu_memwritedata;
    logic [DW-1:0] cpu_memreaddata;
    logic          cpu_stall;
    logic          mem_wr_valid;
    logic          mem_wr_ready;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic [CW-1:0] sb_count;
    logic          sb_empty;

    // Environment view: the core and the data memory.
    modport master (
        output cpu_memwrite, cpu_memaddr, cpu_memwritedata, mem_wr_ready, mem_rd_data,
        input  cpu_memreaddata, cpu_stall, mem_wr_valid, mem_wr_addr, mem_wr_data,
               mem_rd_addr, sb_count, sb_empty
    );

    modport slave (
        input  cpu_memwrite, cpu_memaddr, cpu_memwritedata, mem_wr_ready, mem_rd_data,
        output cpu_memreaddata, cpu_stall, mem_wr_valid, mem_wr_addr, mem_wr_data,
               mem_rd_addr, sb_count, sb_empty
    );
endinterface

// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer: FIFO of MEM-stage stores drained over valid/ready,
// with newest-first load forwarding. Optional store coalescing: STORE_BUF_COALESCE_EN.
module dmem_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic           clk,
    input  logic           reset,
    dmem_store_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW-1:0]    newest;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             retire;
    logic             enq;
    logic             coalesce;
    logic             fwd_hit;
    logic [DW-1:0]    fwd_data;

    function automatic logic same_word(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return a[AW-1:2] == b[AW-1:2];
    endfunction

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign newest = tail - PW'(1);
    assign retire = !empty && bus.mem_wr_ready;

`ifdef STORE_BUF_COALESCE_EN
    // The head is always on the bus while non-empty, so it must never be rewritten.
    assign coalesce = bus.cpu_memwrite && valid_q[newest] && (newest != head) &&
                      same_word(addr_q[newest], bus.cpu_memaddr);
`else
    assign coalesce = 1'b0;
`endif

    assign enq           = bus.cpu_memwrite && !coalesce && (!full || bus.mem_wr_ready);
    assign bus.cpu_stall = bus.cpu_memwrite && !coalesce && full && !bus.mem_wr_ready;

    assign bus.mem_wr_valid = !empty;
    assign bus.mem_wr_addr  = empty ? '0 : addr_q[head];
    assign bus.mem_wr_data  = empty ? '0 : data_q[head];
    assign bus.mem_rd_addr  = bus.cpu_memaddr;
    assign bus.sb_count     = count;
    assign bus.sb_empty     = empty;

    // Walk oldest to newest so the newest matching entry wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx      = '0;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = DEPTH; i >= 1; i--) begin
            idx = tail - PW'(i);
            if (valid_q[idx] && same_word(addr_q[idx], bus.cpu_memaddr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end

    assign bus.cpu_memreaddata = (!bus.cpu_memwrite && fwd_hit) ? fwd_data : bus.mem_rd_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            valid_q <= '0;
        end else begin
            if (retire) begin
                head          <= head + PW'(1);
                valid_q[head] <= 1'b0;
            end
            // Full with a drain: head == tail, so the set below overrides the clear above.
            if (enq) begin
                tail          <= tail + PW'(1);
                valid_q[tail] <= 1'b1;
            end
            count <= count + CW'(enq) - CW'(retire);
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail] <= bus.cpu_memaddr;
            data_q[tail] <= bus.cpu_memwritedata;
        end else if (coalesce) begin
            data_q[newest] <= bus.cpu_memwritedata;
        end
    end
endmodule
